// File: rtl/cu_fsm.sv
// Multicycle control sequencer for the RV32I MCU: fetch / execute / writeback / interrupt.
// The CU_FSM_INTR_EN macro enables csrrw, mret and interrupt entry; undefined, those strobes stay 0.
module cu_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic                 intr,
  input  logic                 mie,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 mem_we2,
  output logic                 mem_rden1,
  output logic                 mem_rden2,
  output logic                 rst_pc,
  output logic                 csr_we,
  output logic                 int_taken,
  output logic                 mret_exec,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 irq_go;

`ifdef CU_FSM_INTR_EN
  assign irq_go = intr & mie;
`else
  logic unused_inputs;
  assign irq_go        = 1'b0;
  assign unused_inputs = intr ^ mie ^ (^func3);
`endif

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d   = state_q;
    instret_d = instret_q;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_we2   = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    rst_pc    = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;

    case (state_q)
      ST_INIT: begin
        rst_pc  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        pc_write = 1'b1;
        case (opcode)
          OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR: reg_write = 1'b1;
          OP_BRANCH: ;
          OP_STORE:  mem_we2 = 1'b1;
          OP_LOAD: begin
            pc_write  = 1'b0;
            mem_rden2 = 1'b1;
          end
          OP_SYSTEM: begin
`ifdef CU_FSM_INTR_EN
            if (func3 == 3'b001) begin
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end else if (func3 == 3'b000) begin
              mret_exec = 1'b1;
            end
`endif
          end
          default: ;
        endcase
        // Loads retire from ST_WB; everything else retires as it leaves ST_EXEC.
        if (opcode == OP_LOAD) begin
          state_d = ST_WB;
        end else begin
          instret_d = instret_q + INSTRET_W'(1);
          state_d   = irq_go ? ST_INTR : ST_FETCH;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        instret_d = instret_q + INSTRET_W'(1);
        state_d   = irq_go ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
`ifdef CU_FSM_INTR_EN
        int_taken = 1'b1;
        pc_write  = 1'b1;
`endif
        state_d = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: per-instruction cycle model plus literal pins.
// Honours CU_FSM_INTR_EN the same way the design does.
module tb_cu_fsm;

  localparam int W = 8;
`ifdef CU_FSM_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  typedef struct packed {
    logic pc_write;
    logic reg_write;
    logic mem_we2;
    logic mem_rden1;
    logic mem_rden2;
    logic rst_pc;
    logic csr_we;
    logic int_taken;
    logic mret_exec;
  } strobes_t;

  typedef struct {
    strobes_t s;
    logic [W-1:0] ir;
  } exp_t;

  localparam logic [6:0] ADDI = 7'b0010011, SW = 7'b0100011, LW = 7'b0000011;
  localparam logic [6:0] SYS  = 7'b1110011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [6:0]   opcode = 7'd0;
  logic [2:0]   func3 = 3'd0;
  logic         intr = 1'b0;
  logic         mie = 1'b0;
  logic         pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rst_pc;
  logic         csr_we, int_taken, mret_exec;
  logic [W-1:0] instret;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_instret = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cu_fsm #(.INSTRET_W(W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .intr(intr), .mie(mie),
    .pc_write(pc_write), .reg_write(reg_write), .mem_we2(mem_we2),
    .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .rst_pc(rst_pc),
    .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec), .instret(instret)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes for one cycle of each phase, taken straight from the opcode table.
  function automatic strobes_t s_init();
    strobes_t s = '0;
    s.rst_pc = 1'b1;
    return s;
  endfunction

  function automatic strobes_t s_fetch();
    strobes_t s = '0;
    s.mem_rden1 = 1'b1;
    return s;
  endfunction

  function automatic strobes_t s_wb();
    strobes_t s = '0;
    s.pc_write  = 1'b1;
    s.reg_write = 1'b1;
    return s;
  endfunction

  function automatic strobes_t s_intr();
    strobes_t s = '0;
    s.pc_write  = 1'b1;
    s.int_taken = 1'b1;
    return s;
  endfunction

  function automatic strobes_t s_exec(input logic [6:0] op, input logic [2:0] f3);
    strobes_t s = '0;
    s.pc_write = 1'b1;
    case (op)
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111:
        s.reg_write = 1'b1;
      7'b0100011: s.mem_we2 = 1'b1;
      7'b0000011: begin
        s.pc_write  = 1'b0;
        s.mem_rden2 = 1'b1;
      end
      7'b1110011: begin
        if (INTR_EN && f3 == 3'b001) begin
          s.reg_write = 1'b1;
          s.csr_we    = 1'b1;
        end else if (INTR_EN && f3 == 3'b000) begin
          s.mret_exec = 1'b1;
        end
      end
      default: ;
    endcase
    return s;
  endfunction

  // One clock: drive inputs just after the edge and queue what this cycle must show.
  task automatic cyc(input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic irq, input logic ie, input bit chk, input strobes_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; func3 = f3; intr = irq; mie = ie;
    if (chk) begin
      e.s  = s;
      e.ir = W'(m_instret);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("strobes", {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, rst_pc,
                        csr_we, int_taken, mret_exec}, e.s);
      check("instret", instret, e.ir);
    end
  end

  task automatic reset_seq(input int n);
    cyc(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, s_init());
    m_instret = 0;
    for (int i = 1; i < n; i++) cyc(1'b1, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, s_init());
    cyc(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, s_init());
  endtask

  // Whole instruction from ST_FETCH: irq_f is intr during fetch, irq/ie apply from execute on.
  task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                       input logic irq, input logic ie, input logic irq_f);
    cyc(1'b0, op, f3, irq_f, ie, 1'b1, s_fetch());
    cyc(1'b0, op, f3, irq, ie, 1'b1, s_exec(op, f3));
    if (op == LW) cyc(1'b0, op, f3, irq, ie, 1'b1, s_wb());
    m_instret = (m_instret + 1) % (1 << W);
    if (INTR_EN && irq && ie) cyc(1'b0, op, f3, irq, ie, 1'b1, s_intr());
  endtask

  task automatic lit_check();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_seq(2);
    lit_check();
    check("lit_init_rst_pc", rst_pc, 1);
    check("lit_init_instret", instret, 0);

    instr(ADDI, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(SW,   3'd2, 1'b0, 1'b0, 1'b0);
    instr(LW,   3'd2, 1'b0, 1'b0, 1'b0);
    instr(ADDI, 3'd0, 1'b0, 1'b0, 1'b0);
    lit_check();
    check("lit_instret_after_3", instret, 3);

    instr(ADDI, 3'd0, 1'b1, 1'b1, 1'b0);
    instr(ADDI, 3'd0, 1'b1, 1'b0, 1'b0);
    instr(ADDI, 3'd0, 1'b0, 1'b1, 1'b1);
    instr(LW,   3'd2, 1'b1, 1'b1, 1'b0);
    instr(SW,   3'd2, 1'b1, 1'b1, 1'b1);

    instr(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0);
    instr(7'b0001111, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(7'b1111111, 3'd7, 1'b0, 1'b0, 1'b0);
    instr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(SYS, 3'b000, 1'b0, 1'b0, 1'b0);
    instr(SYS, 3'b010, 1'b0, 1'b0, 1'b0);
    instr(SYS, 3'b001, 1'b0, 1'b0, 1'b0);
    lit_check();
    check("lit_csrrw_pc_write", pc_write, 1);
    check("lit_csrrw_csr_we", csr_we, INTR_EN ? 1 : 0);
    check("lit_csrrw_reg_write", reg_write, INTR_EN ? 1 : 0);

    // Reset asserted while in ST_WB: the load must not retire or write again.
    cyc(1'b0, LW, 3'd2, 1'b0, 1'b0, 1'b1, s_fetch());
    cyc(1'b0, LW, 3'd2, 1'b0, 1'b0, 1'b1, s_exec(LW, 3'd2));
    cyc(1'b1, LW, 3'd2, 1'b0, 1'b0, 1'b1, s_wb());
    m_instret = 0;
    cyc(1'b0, LW, 3'd2, 1'b0, 1'b0, 1'b1, s_init());
    lit_check();
    check("lit_rst_wb_reg_write", reg_write, 0);
    check("lit_rst_wb_rst_pc", rst_pc, 1);
    check("lit_rst_wb_instret", instret, 0);

    for (int i = 0; i < 256; i++) instr(ADDI, 3'd0, 1'b0, 1'b0, 1'b0);
    instr(ADDI, 3'd0, 1'b0, 1'b0, 1'b0);
    lit_check();
    check("lit_instret_wrap", instret, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
